// File: rtl/bus_pkg.sv
// Shared types and constants for the core memory-bus arbiter.
package bus_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam logic [3:0] BUS_BE_ALL = 4'hF;

endpackage

// File: rtl/bus_arbiter_owner_fifo.sv
// Small FIFO remembering which requester owns each outstanding bus transaction.
module owner_fifo
  import bus_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_e push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam logic [PW-1:0] LAST = PW'(Depth - 1);

  owner_e         mem_reg [Depth];
  logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           do_push, do_pop;

  assign full    = (count_reg == CW'(Depth));
  assign empty   = (count_reg == '0);
  assign head    = mem_reg[rd_ptr_reg];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + PW'(1);
    if (do_pop)  rd_ptr_next = (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + PW'(1);
    // Simultaneous push and pop leave the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_reg[wr_ptr_reg] <= push_owner;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester (fetch, load/store) arbiter for a single in-order req/gnt/rvalid bus.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_req_i,
  input  logic [BUS_AW-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [BUS_DW-1:0] instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic [BUS_AW-1:0] data_addr_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [BUS_DW-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [BUS_DW-1:0] data_rdata_o,
  output logic              data_err_o,
  output logic              mem_req_o,
  output logic [BUS_AW-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [BUS_DW-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [BUS_DW-1:0] mem_rdata_i,
  input  logic              mem_err_i,
  output logic              unexp_rsp_o
);

  localparam logic [3:0] LIMIT = 4'(StarveLimit);

  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       unexp_reg, unexp_next;
  logic       sel_data, bus_req, bus_gnt, rsp_valid;
  logic       fifo_full, fifo_empty;
  owner_e     fifo_head;

  // Data has priority unless the fetch side has already waited StarveLimit grants.
  assign sel_data  = data_req_i & (~instr_req_i | (starve_cnt_reg != LIMIT));
  assign bus_req   = (instr_req_i | data_req_i) & ~fifo_full & ~rst;
  assign bus_gnt   = bus_req & mem_gnt_i;
  assign rsp_valid = mem_rvalid_i & ~fifo_empty & ~rst;

  owner_fifo #(
    .Depth(MaxOutstanding)
  ) u_owner_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus_gnt),
    .push_owner(sel_data ? OWNER_DATA : OWNER_INSTR),
    .pop       (rsp_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    unexp_next      = unexp_reg;
    if (bus_gnt && !sel_data) begin
      starve_cnt_next = '0;
    end else if (bus_gnt && instr_req_i && starve_cnt_reg != LIMIT) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
    if (mem_rvalid_i && fifo_empty) unexp_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      unexp_reg      <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      unexp_reg      <= unexp_next;
    end
  end

  always_comb begin
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_wdata_o    = '0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    instr_err_o    = 1'b0;
    data_err_o     = 1'b0;
    instr_rdata_o  = '0;
    data_rdata_o   = '0;
    unexp_rsp_o    = 1'b0;
    if (!rst) begin
      mem_req_o      = bus_req;
      mem_addr_o     = sel_data ? data_addr_i : instr_addr_i;
      mem_we_o       = sel_data & data_we_i;
      mem_be_o       = sel_data ? data_be_i : BUS_BE_ALL;
      mem_wdata_o    = sel_data ? data_wdata_i : '0;
      instr_gnt_o    = bus_gnt & ~sel_data;
      data_gnt_o     = bus_gnt & sel_data;
      instr_rvalid_o = rsp_valid & (fifo_head == OWNER_INSTR);
      data_rvalid_o  = rsp_valid & (fifo_head == OWNER_DATA);
      instr_err_o    = instr_rvalid_o & mem_err_i;
      data_err_o     = data_rvalid_o & mem_err_i;
      instr_rdata_o  = mem_rdata_i;
      data_rdata_o   = mem_rdata_i;
      unexp_rsp_o    = unexp_reg;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter against a queue-based reference model.
module tb_bus_arbiter;

  localparam int MO = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i, data_req_i, data_we_i;
  logic [31:0] instr_addr_i, data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;
  logic        unexp_rsp_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MaxOutstanding(MO), .StarveLimit(SL)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .unexp_rsp_o(unexp_rsp_o)
  );

  // Reference model: a queue of owners (0 = instr, 1 = data) in issue order.
  bit oq[$];
  int m_starve;
  bit m_unexp;

  logic        e_mem_req, e_igrant, e_dgrant, e_we, e_irv, e_drv, e_ierr, e_derr, e_unexp;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;
  bit          e_sel_data;

  task automatic model_eval();
    bit full;
    full       = (oq.size() >= MO);
    e_sel_data = data_req_i && (!instr_req_i || m_starve != SL);
    e_mem_req  = !rst && (instr_req_i || data_req_i) && !full;
    e_igrant   = e_mem_req && mem_gnt_i && !e_sel_data;
    e_dgrant   = e_mem_req && mem_gnt_i && e_sel_data;
    e_addr     = rst ? 32'h0 : (e_sel_data ? data_addr_i : instr_addr_i);
    e_we       = !rst && e_sel_data && data_we_i;
    e_be       = rst ? 4'h0 : (e_sel_data ? data_be_i : 4'hF);
    e_wdata    = (rst || !e_sel_data) ? 32'h0 : data_wdata_i;
    e_irv      = !rst && mem_rvalid_i && oq.size() > 0 && oq[0] == 1'b0;
    e_drv      = !rst && mem_rvalid_i && oq.size() > 0 && oq[0] == 1'b1;
    e_ierr     = e_irv && mem_err_i;
    e_derr     = e_drv && mem_err_i;
    e_rdata    = rst ? 32'h0 : mem_rdata_i;
    e_unexp    = !rst && m_unexp;
  endtask

  task automatic model_commit();
    if (rst) begin
      oq.delete();
      m_starve = 0;
      m_unexp  = 1'b0;
    end else begin
      if (mem_rvalid_i) begin
        if (oq.size() > 0) void'(oq.pop_front());
        else m_unexp = 1'b1;
      end
      if (e_igrant) begin
        oq.push_back(1'b0);
        m_starve = 0;
      end else if (e_dgrant) begin
        oq.push_back(1'b1);
        if (instr_req_i && m_starve < SL) m_starve++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0;
    data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    #1 model_eval();
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    mem_rdata_i = 32'hCAFE0001;
    #1 model_eval();
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {instr_gnt_o, data_gnt_o}); end
    n_checks++; if ({instr_rvalid_o, data_rvalid_o, unexp_rsp_o} !== 3'b000) begin n_fail++; $display("FAIL reset_rsp: got %b want 000", {instr_rvalid_o, data_rvalid_o, unexp_rsp_o}); end
    n_checks++; if (mem_be_o !== 4'h0 || instr_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: be %h rdata %h want 0 0", mem_be_o, instr_rdata_o); end
    step();
    step();
    rst = 0;
    set_idle();
  endtask

  task automatic test_single_fetch();
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    #1 model_eval();
    n_checks++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt: got i%b d%b want i1 d0", instr_gnt_o, data_gnt_o); end
    n_checks++; if (mem_addr_o !== 32'h100 || mem_be_o !== 4'hF) begin n_fail++; $display("FAIL fetch_bus: addr %h be %h want 100 f", mem_addr_o, mem_be_o); end
    step();
    set_idle();
    mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    #1 model_eval();
    n_checks++; if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid: got i%b d%b want i1 d0", instr_rvalid_o, data_rvalid_o); end
    n_checks++; if (instr_rdata_o !== 32'h13) begin n_fail++; $display("FAIL fetch_rdata: got %h want 00000013", instr_rdata_o); end
    step();
    set_idle();
  endtask

  task automatic test_starvation();
    bit exp_data;
    do_reset();
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1;
    instr_addr_i = 32'h200; data_addr_i = 32'h300;
    for (int i = 0; i < 11; i++) begin
      mem_rvalid_i = (i > 0);
      #1 model_eval();
      exp_data = (i != SL) && (i != 2 * SL + 1);
      n_checks++;
      if (data_gnt_o !== exp_data || instr_gnt_o !== !exp_data) begin
        n_fail++; $display("FAIL starve_c%0d: got i%b d%b want i%b d%b", i, instr_gnt_o, data_gnt_o, !exp_data, exp_data);
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_full();
    bit exp_req;
    do_reset();
    instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid_i = (i == 3);
      #1 model_eval();
      exp_req = (i != 2) && (i != 3);
      n_checks++;
      if (mem_req_o !== exp_req || instr_gnt_o !== exp_req) begin
        n_fail++; $display("FAIL full_c%0d: req %b gnt %b want %b", i, mem_req_o, instr_gnt_o, exp_req);
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_interleave();
    bit          t_ireq [5] = '{1, 0, 0, 1, 0};
    bit          t_dreq [5] = '{0, 1, 0, 0, 0};
    bit          t_rv   [5] = '{0, 0, 1, 1, 1};
    logic [31:0] t_rd   [5] = '{32'h0, 32'h0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    bit          t_iv   [5] = '{0, 0, 1, 0, 1};
    do_reset();
    mem_gnt_i = 1;
    for (int i = 0; i < 5; i++) begin
      instr_req_i = t_ireq[i]; data_req_i = t_dreq[i];
      mem_rvalid_i = t_rv[i]; mem_rdata_i = t_rd[i];
      #1 model_eval();
      n_checks++;
      if (instr_rvalid_o !== (t_iv[i] & 1'b1) || data_rvalid_o !== (t_rv[i] & ~t_iv[i])) begin
        n_fail++; $display("FAIL interleave_c%0d: got i%b d%b want i%b d%b", i, instr_rvalid_o, data_rvalid_o, t_iv[i], t_rv[i] & ~t_iv[i]);
      end
      if (t_rv[i]) begin
        n_checks++;
        if ((t_iv[i] ? instr_rdata_o : data_rdata_o) !== t_rd[i]) begin
          n_fail++; $display("FAIL interleave_rdata_c%0d: got %h want %h", i, t_iv[i] ? instr_rdata_o : data_rdata_o, t_rd[i]);
        end
      end
      step();
    end
    set_idle();
  endtask

  task automatic test_store();
    do_reset();
    data_req_i = 1; data_addr_i = 32'h8000; data_we_i = 1; data_be_i = 4'h3;
    data_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1;
    #1 model_eval();
    n_checks++; if (mem_we_o !== 1'b1 || mem_be_o !== 4'h3) begin n_fail++; $display("FAIL store_ctl: we %b be %h want 1 3", mem_we_o, mem_be_o); end
    n_checks++; if (mem_wdata_o !== 32'hDEADBEEF || data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL store_data: wdata %h gnt %b want deadbeef 1", mem_wdata_o, data_gnt_o); end
    step();
    set_idle();
    mem_rvalid_i = 1; mem_err_i = 1;
    #1 model_eval();
    n_checks++; if (data_err_o !== 1'b1 || instr_err_o !== 1'b0 || data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL store_err: derr %b ierr %b drv %b want 1 0 1", data_err_o, instr_err_o, data_rvalid_o); end
    step();
    set_idle();
  endtask

  task automatic test_unexp_after_reset();
    do_reset();
    instr_req_i = 1; mem_gnt_i = 1;
    #1 model_eval(); step();
    #1 model_eval(); step();
    set_idle();
    rst = 1;
    #1 model_eval(); step();
    rst = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    #1 model_eval();
    n_checks++; if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL unexp_rvalid: got i%b d%b want 0 0", instr_rvalid_o, data_rvalid_o); end
    step();
    set_idle();
    instr_req_i = 1;
    #1 model_eval();
    n_checks++; if (unexp_rsp_o !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky: got %b want 1", unexp_rsp_o); end
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL unexp_count: mem_req %b want 1", mem_req_o); end
    step();
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      instr_req_i  = $urandom_range(0, 1);
      data_req_i   = $urandom_range(0, 1);
      instr_addr_i = $urandom;
      data_addr_i  = $urandom;
      data_we_i    = $urandom_range(0, 1);
      data_be_i    = 4'($urandom);
      data_wdata_i = $urandom;
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = (oq.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
      mem_rdata_i  = $urandom;
      mem_err_i    = ($urandom_range(0, 7) == 0);
      #1 model_eval();
      n_checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o} !== {e_mem_req, e_igrant, e_dgrant}) begin
        n_fail++; $display("FAIL rand_gnt_c%0d: req/ig/dg %b want %b", i, {mem_req_o, instr_gnt_o, data_gnt_o}, {e_mem_req, e_igrant, e_dgrant});
      end
      n_checks++;
      if (mem_addr_o !== e_addr || mem_we_o !== e_we || mem_be_o !== e_be || mem_wdata_o !== e_wdata) begin
        n_fail++; $display("FAIL rand_bus_c%0d: addr %h we %b be %h wd %h want %h %b %h %h", i, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, e_addr, e_we, e_be, e_wdata);
      end
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, unexp_rsp_o} !== {e_irv, e_drv, e_ierr, e_derr, e_unexp}) begin
        n_fail++; $display("FAIL rand_rsp_c%0d: irv/drv/ie/de/ux %b want %b", i, {instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, unexp_rsp_o}, {e_irv, e_drv, e_ierr, e_derr, e_unexp});
      end
      n_checks++;
      if (instr_rdata_o !== e_rdata || data_rdata_o !== e_rdata) begin
        n_fail++; $display("FAIL rand_rdata_c%0d: i %h d %h want %h", i, instr_rdata_o, data_rdata_o, e_rdata);
      end
      step();
    end
    set_idle();
  endtask

  initial begin
    rst = 1;
    set_idle();
    m_starve = 0;
    m_unexp  = 0;
    #1;
    test_reset();
    test_single_fetch();
    test_starvation();
    test_full();
    test_interleave();
    test_store();
    test_unexp_after_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
